pcs_rx_block_lock_ctrl: RTL and testbench

Receive-side sequencer for the 64-bit parallel descrambler (g(x) = x^58 + x^39 + 1) in the 40G/100G PCS.
- Monitors 2-bit sync headers from the gearbox and runs the block-lock state machine.
- Issues bitslip requests to the gearbox.
- Gates descrambler state advance and clears descrambler state on slip.
- Forwards aligned blocks with a valid qualifier only while locked.

---
 rtl/pcs_rx_block_lock_ctrl.sv | 165 ++++++++++++++++
 tb/tb_pcs_rx_block_lock_ctrl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pcs_rx_block_lock_ctrl.sv
// Receive-side block-lock sequencer for the 64b/66b PCS descrambler path.
// Hunts for sync-header alignment, requests bitslips, gates the descrambler and forwards locked blocks.
//
// state     | meaning
// ----------+----------------------------------------------------------
// HUNT      | counting consecutive valid headers toward lock
// SLIP_WAIT | bitslip issued, waiting for the gearbox to realign
// LOCKED    | aligned; monitoring invalid headers per window
module pcs_rx_block_lock_ctrl #(
  parameter int LOCK_CNT  = 64,
  parameter int INV_LIMIT = 16,
  parameter int SLIP_WAIT = 8,
  parameter int ERR_CNT_W = 16
) (
  input  logic                 CLK,
  input  logic                 rst,
  input  logic                 rx_valid,
  input  logic [1:0]           rx_hdr,
  input  logic [63:0]          rx_data,
  output logic                 bitslip,
  output logic                 descr_en,
  output logic                 descr_clr,
  output logic                 block_lock,
  output logic                 out_valid,
  output logic [1:0]           out_hdr,
  output logic [63:0]          out_data,
  output logic [ERR_CNT_W-1:0] hdr_err_cnt
);

  localparam int SH_W   = $clog2(LOCK_CNT + 1);
  localparam int INV_W  = $clog2(INV_LIMIT + 1);
  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  typedef enum logic [1:0] {
    ST_HUNT      = 2'd0,
    ST_SLIP_WAIT = 2'd1,
    ST_LOCKED    = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [SH_W-1:0]       r_sh_cnt;
  logic [INV_W-1:0]      r_inv_cnt;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic                  r_bitslip;
  logic                  r_descr_clr;
  logic                  r_block_lock;
  logic                  r_out_valid;
  logic [1:0]            r_out_hdr;
  logic [63:0]           r_out_data;
  logic [ERR_CNT_W-1:0]  r_hdr_err_cnt;

  logic                  w_hdr_ok;
  logic                  w_beat;
  logic                  w_sh_full;
  logic                  w_inv_hit;
  logic                  w_slip;
  logic                  w_lock_acq;
  logic                  w_win_end;
  logic                  w_descr_en;
  logic [SH_W-1:0]       w_sh_inc;
  logic [INV_W-1:0]      w_inv_inc;

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_hdr_ok    = rx_hdr[1] ^ rx_hdr[0];
    w_beat      = rx_valid && (r_state != ST_SLIP_WAIT);
    w_sh_inc    = r_sh_cnt + SH_W'(1);
    w_inv_inc   = r_inv_cnt + INV_W'(1);
    w_sh_full   = (w_sh_inc == SH_W'(LOCK_CNT));
    w_inv_hit   = !w_hdr_ok && (w_inv_inc == INV_W'(INV_LIMIT));
    // Loss of lock takes priority over a window restart on the same beat.
    w_slip      = rx_valid && (((r_state == ST_HUNT) && !w_hdr_ok) ||
                               ((r_state == ST_LOCKED) && w_inv_hit));
    w_lock_acq  = rx_valid && (r_state == ST_HUNT) && w_hdr_ok && w_sh_full;
    w_win_end   = rx_valid && (r_state == ST_LOCKED) && !w_inv_hit && w_sh_full;
    w_state_nxt = r_state;
    case (r_state)
      ST_HUNT: begin
        if (w_slip) begin
          w_state_nxt = ST_SLIP_WAIT;
        end else if (w_lock_acq) begin
          w_state_nxt = ST_LOCKED;
        end
      end
      ST_SLIP_WAIT: begin
        if (r_wait_cnt == '0) begin
          w_state_nxt = ST_HUNT;
        end
      end
      ST_LOCKED: begin
        if (w_slip) begin
          w_state_nxt = ST_SLIP_WAIT;
        end
      end
      default: w_state_nxt = ST_HUNT;
    endcase
  end

  always_comb begin
    w_descr_en = rx_valid && (r_state != ST_SLIP_WAIT);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      r_sh_cnt      <= '0;
      r_inv_cnt     <= '0;
      r_wait_cnt    <= '0;
      r_bitslip     <= 1'b0;
      r_descr_clr   <= 1'b0;
      r_block_lock  <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_hdr     <= '0;
      r_out_data    <= '0;
      r_hdr_err_cnt <= '0;
    end else begin
      if (w_slip) begin
        r_wait_cnt <= WAIT_W'(SLIP_WAIT - 1);
      end else if ((r_state == ST_SLIP_WAIT) && (r_wait_cnt != '0)) begin
        r_wait_cnt <= r_wait_cnt - WAIT_W'(1);
      end

      if (w_slip || w_lock_acq || w_win_end) begin
        r_sh_cnt  <= '0;
        r_inv_cnt <= '0;
      end else if (w_beat) begin
        r_sh_cnt <= w_sh_inc;
        if ((r_state == ST_LOCKED) && !w_hdr_ok) begin
          r_inv_cnt <= w_inv_inc;
        end
      end

      if (w_beat && (r_state == ST_LOCKED) && !w_hdr_ok && !(&r_hdr_err_cnt)) begin
        r_hdr_err_cnt <= r_hdr_err_cnt + ERR_CNT_W'(1);
      end

      r_bitslip    <= w_slip;
      r_descr_clr  <= w_slip;
      r_block_lock <= (w_state_nxt == ST_LOCKED);
      r_out_valid  <= w_beat && (r_state == ST_LOCKED) && !w_slip;

      if (rx_valid) begin
        r_out_hdr  <= rx_hdr;
        r_out_data <= rx_data;
      end
    end
  end

  assign bitslip     = r_bitslip;
  assign descr_en    = w_descr_en;
  assign descr_clr   = r_descr_clr;
  assign block_lock  = r_block_lock;
  assign out_valid   = r_out_valid;
  assign out_hdr     = r_out_hdr;
  assign out_data    = r_out_data;
  assign hdr_err_cnt = r_hdr_err_cnt;

endmodule

// File: tb/tb_pcs_rx_block_lock_ctrl.sv
// Bench for pcs_rx_block_lock_ctrl: directed scenarios plus random traffic,
// every cycle compared against a beat-level behavioural model.
module tb_pcs_rx_block_lock_ctrl;
  localparam int LOCK_CNT  = 64;
  localparam int INV_LIMIT = 16;
  localparam int SLIP_WAIT = 8;
  localparam int ERR_W     = 16;

  logic             CLK = 1'b0;
  logic             rst;
  logic             rx_valid;
  logic [1:0]       rx_hdr;
  logic [63:0]      rx_data;
  logic             bitslip, descr_en, descr_clr, block_lock, out_valid;
  logic [1:0]       out_hdr;
  logic [63:0]      out_data;
  logic [ERR_W-1:0] hdr_err_cnt;

  pcs_rx_block_lock_ctrl #(
    .LOCK_CNT(LOCK_CNT), .INV_LIMIT(INV_LIMIT), .SLIP_WAIT(SLIP_WAIT), .ERR_CNT_W(ERR_W)
  ) dut (
    .CLK(CLK), .rst(rst), .rx_valid(rx_valid), .rx_hdr(rx_hdr), .rx_data(rx_data),
    .bitslip(bitslip), .descr_en(descr_en), .descr_clr(descr_clr),
    .block_lock(block_lock), .out_valid(out_valid), .out_hdr(out_hdr),
    .out_data(out_data), .hdr_err_cnt(hdr_err_cnt)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  // Reference: lock flag, remaining hold-off cycles, beats counted, bad headers counted.
  bit          m_locked;
  int          m_wait, m_good, m_bad, m_err;
  bit          e_bs, e_clr, e_ov;
  logic [1:0]  e_hdr;
  logic [63:0] e_data;

  function automatic bit good_hdr(input logic [1:0] h);
    return (h == 2'b01) || (h == 2'b10);
  endfunction

  function automatic logic [1:0] rgood();
    return ($urandom_range(0, 1) == 1) ? 2'b01 : 2'b10;
  endfunction

  function automatic logic [1:0] rbad();
    return ($urandom_range(0, 1) == 1) ? 2'b00 : 2'b11;
  endfunction

  function automatic logic [63:0] rdata();
    return {$urandom, $urandom};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_wait = 0; m_good = 0; m_bad = 0; m_err = 0;
    e_bs = 0; e_clr = 0; e_ov = 0; e_hdr = '0; e_data = '0;
  endtask

  task automatic model_edge(input bit r, input bit v, input logic [1:0] h, input logic [63:0] d);
    bit slip;
    slip = 0; e_bs = 0; e_clr = 0; e_ov = 0;
    if (r) begin
      model_reset();
      return;
    end
    if (v) begin
      e_hdr = h; e_data = d;
    end
    if (m_wait > 0) begin
      m_wait--;
    end else if (v) begin
      if (!m_locked) begin
        if (good_hdr(h)) begin
          m_good++;
          if (m_good == LOCK_CNT) begin
            m_locked = 1; m_good = 0; m_bad = 0;
          end
        end else begin
          slip = 1;
        end
      end else begin
        m_good++;
        if (!good_hdr(h)) begin
          m_bad++;
          if (m_err < (1 << ERR_W) - 1) m_err++;
        end
        if (m_bad == INV_LIMIT) begin
          slip = 1; m_locked = 0;
        end else begin
          e_ov = 1;
          if (m_good == LOCK_CNT) begin
            m_good = 0; m_bad = 0;
          end
        end
      end
    end
    if (slip) begin
      e_bs = 1; e_clr = 1; m_wait = SLIP_WAIT; m_good = 0; m_bad = 0;
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [1:0] h, input logic [63:0] d);
    rst = r; rx_valid = v; rx_hdr = h; rx_data = d;
    #1;
    chk("descr_en", descr_en, 64'(v && (m_wait == 0)));
    @(posedge CLK);
    model_edge(r, v, h, d);
    #1;
    chk("bitslip", bitslip, 64'(e_bs));
    chk("descr_clr", descr_clr, 64'(e_clr));
    chk("block_lock", block_lock, 64'(m_locked));
    chk("out_valid", out_valid, 64'(e_ov));
    chk("out_hdr", out_hdr, 64'(e_hdr));
    chk("out_data", out_data, e_data);
    chk("hdr_err_cnt", hdr_err_cnt, 64'(m_err));
    @(negedge CLK);
  endtask

  initial begin
    bit bad_pos [64];
    int cnt, idx, rate;

    rst = 1'b1; rx_valid = 1'b0; rx_hdr = '0; rx_data = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    step(1, 0, 2'b00, 64'h0);

    // Clean acquisition; first forwarded beat is the one after lock.
    for (int i = 1; i <= 64; i++) begin
      step(0, 1, rgood(), rdata());
      if (i == 63) chk("t1_not_yet_locked", block_lock, 0);
    end
    chk("t1_locked", block_lock, 1);
    chk("t1_beat64_not_fwd", out_valid, 0);
    step(0, 1, 2'b01, 64'hDEAD_BEEF_0000_0001);
    chk("t1_beat65_valid", out_valid, 1);
    chk("t1_beat65_data", out_data, 64'hDEAD_BEEF_0000_0001);

    // Bad header while hunting.
    step(1, 0, 2'b00, 64'h0);
    for (int i = 1; i <= 9; i++) step(0, 1, rgood(), rdata());
    step(0, 1, 2'b11, rdata());
    chk("t2_bitslip", bitslip, 1);
    chk("t2_descr_clr", descr_clr, 1);
    for (int i = 0; i < SLIP_WAIT; i++) begin
      step(0, 1, rgood(), rdata());
      if (i == 0) chk("t2_bitslip_one_cycle", bitslip, 0);
    end
    for (int i = 1; i <= 63; i++) step(0, 1, rgood(), rdata());
    chk("t2_not_locked_63", block_lock, 0);
    step(0, 1, rgood(), rdata());
    chk("t2_locked_64", block_lock, 1);

    // 15 bad headers in one window: hold lock.
    foreach (bad_pos[k]) bad_pos[k] = 0;
    cnt = 0;
    while (cnt < INV_LIMIT - 1) begin
      idx = $urandom_range(0, 63);
      if (!bad_pos[idx]) begin bad_pos[idx] = 1; cnt++; end
    end
    for (int i = 0; i < 64; i++) step(0, 1, bad_pos[i] ? rbad() : rgood(), rdata());
    chk("t3_lock_held", block_lock, 1);
    chk("t3_err_cnt_15", hdr_err_cnt, 15);

    // 16 bad headers in the next window: lose lock on the 16th.
    foreach (bad_pos[k]) bad_pos[k] = 0;
    cnt = 0;
    while (cnt < INV_LIMIT) begin
      idx = $urandom_range(0, 63);
      if (!bad_pos[idx]) begin bad_pos[idx] = 1; cnt++; end
    end
    cnt = 0;
    for (int i = 0; i < 64; i++) begin
      if (cnt < INV_LIMIT) begin
        if (bad_pos[i]) cnt++;
        step(0, 1, bad_pos[i] ? rbad() : rgood(), rdata());
      end
    end
    chk("t3_lock_lost", block_lock, 0);
    chk("t3_bitslip", bitslip, 1);
    chk("t3_no_fwd_loss_beat", out_valid, 0);
    chk("t3_err_cnt_31", hdr_err_cnt, 31);

    // Relock, then 15 bad early and the 64th beat bad.
    for (int i = 0; i < SLIP_WAIT; i++) step(0, 0, 2'b00, 64'h0);
    for (int i = 0; i < 64; i++) step(0, 1, rgood(), rdata());
    chk("t4_relocked", block_lock, 1);
    for (int i = 1; i <= 64; i++) begin
      step(0, 1, ((i <= 15) || (i == 64)) ? rbad() : rgood(), rdata());
      if (i == 63) chk("t4_held_63", block_lock, 1);
    end
    chk("t4_loss_wins", block_lock, 0);
    chk("t4_bitslip", bitslip, 1);
    chk("t4_err_cnt_47", hdr_err_cnt, 47);

    // Reset on the third SLIP_WAIT cycle.
    step(0, 0, 2'b00, 64'h0);
    step(0, 0, 2'b00, 64'h0);
    step(1, 1, 2'b01, rdata());
    chk("t6_bitslip", bitslip, 0);
    chk("t6_descr_clr", descr_clr, 0);
    chk("t6_block_lock", block_lock, 0);
    chk("t6_out_valid", out_valid, 0);
    chk("t6_out_hdr", out_hdr, 0);
    chk("t6_out_data", out_data, 0);
    chk("t6_err_cnt", hdr_err_cnt, 0);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 2'b00, 64'h0);
      chk("t6_no_late_bitslip", bitslip, 0);
    end
    rx_valid = 1'b1; rx_hdr = 2'b10;
    #1;
    chk("t6_hunt_descr_en", descr_en, 1);
    @(negedge CLK);

    // Alternating rx_valid during acquisition.
    step(1, 0, 2'b00, 64'h0);
    for (int c = 1; c <= 127; c++) begin
      step(0, (c % 2) == 1, rgood(), rdata());
      if (c == 126) chk("t5_not_locked_126", block_lock, 0);
      if (c == 127) chk("t5_locked_127", block_lock, 1);
    end

    // Random traffic at several header error rates (per mille).
    step(1, 0, 2'b00, 64'h0);
    for (int b = 0; b < 6; b++) begin
      case (b % 4)
        0: rate = 0;
        1: rate = 40;
        2: rate = 150;
        default: rate = 320;
      endcase
      for (int i = 0; i < 600; i++) begin
        step(0, $urandom_range(0, 99) < 75,
             ($urandom_range(0, 999) < rate) ? rbad() : rgood(), rdata());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
